// File: rtl/wb_slave_pkg.sv
// Shared types and widths for the Wishbone register-bank slave.
// The state encoding is exported so assertion binds can decode it.
package wb_slave_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10,
    ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/wb_regbank.sv
// Register storage: byte-enabled write port, asynchronous read port.
// Asynchronous active-low clear of every register.
module wb_regbank
  import wb_slave_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (widx == ADDR_W'(i)) begin
          for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) begin
              mem[i][8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Out-of-range indices read as zero rather than X
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/wb_slave_fsm.sv
// Wishbone classic slave: wait states, error on bad index,
// registered ack/err/read data over a small register bank.
module wb_slave_fsm
  import wb_slave_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output state_t            state_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [3:0]      WC    = 4'(WAIT_CYCLES);

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   rdata;
  logic                req;
  logic                bad;
  logic                we;

  assign req = wb_cyc_i & wb_stb_i;
  assign bad = {1'b0, wb_adr_i} >= LIMIT;
  // With no wait states the read happens on the accepting edge
  assign rd_idx = (state == IDLE) ? wb_adr_i : idx;
  assign we = (state == ACK) & req & wb_we_i;

  wb_regbank #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .widx  (idx),
    .sel   (wb_sel_i),
    .wdata (wb_dat_i),
    .ridx  (rd_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            idx <= wb_adr_i;
            if (bad) begin
              state    <= ERR;
              wb_err_o <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state    <= ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= rdata;
            end else begin
              state <= WAIT;
              cnt   <= WC - 4'd1;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state    <= ACK;
            wb_ack_o <= 1'b1;
            wb_dat_o <= rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_wb_slave_fsm.sv
// Scoreboard bench: three slaves (WAIT_CYCLES 1, 3, 0) on one bus,
// cyc steered to one slave at a time; a monitor checks every ack/err.
module tb_wb_slave_fsm;
  import wb_slave_pkg::*;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  adr = 0, sel = 0;
  logic [31:0] din = 0;
  int          dsel = 0;
  logic [2:0]  cyc_v, ack, err;
  logic [31:0] dout [3];
  logic [1:0]  st [3];
  exp_t        sbq [3][$];
  int          nvec = 0, nbad = 0;

  always #5 clk = ~clk;

  assign cyc_v[0] = cyc && dsel == 0;
  assign cyc_v[1] = cyc && dsel == 1;
  assign cyc_v[2] = cyc && dsel == 2;

  wb_slave_fsm #(.ADDR_W(4), .NUM_REGS(8), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(din), .wb_sel_i(sel),
    .wb_dat_o(dout[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
    .state_o(st[0]));

  wb_slave_fsm #(.ADDR_W(4), .NUM_REGS(8), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(din), .wb_sel_i(sel),
    .wb_dat_o(dout[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
    .state_o(st[1]));

  wb_slave_fsm #(.ADDR_W(4), .NUM_REGS(8), .WAIT_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(din), .wb_sel_i(sel),
    .wb_dat_o(dout[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]),
    .state_o(st[2]));

  // Monitor: every termination must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ack[k] && err[k]) begin
        nbad++;
        $display("FAIL dut%0d ack_err_both: ack=%b err=%b", k, ack[k], err[k]);
      end
      if (ack[k] || err[k]) begin
        nvec++;
        if (sbq[k].size() == 0) begin
          nbad++;
          $display("FAIL dut%0d unexpected_term: ack=%b err=%b want none",
                   k, ack[k], err[k]);
        end else begin
          e = sbq[k].pop_front();
          if (e.is_err != err[k] || (e.chk && dout[k] !== e.dat)) begin
            nbad++;
            $display("FAIL dut%0d term: err=%b dat=%h want err=%b dat=%h",
                     k, err[k], dout[k], e.is_err, e.dat);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic xfer(input int k, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int lat, input bit is_err, input bit chk,
                      input logic [31:0] ed, input bit chg_adr = 0,
                      input bit drop_stb = 0);
    exp_t e;
    int   n;
    e.is_err = is_err;
    e.chk = chk;
    e.dat = ed;
    sbq[k].push_back(e);
    dsel = k; cyc = 1; stb = 1; we = w; adr = a; din = d; sel = s;
    @(posedge clk);
    #1;
    if (chg_adr) adr = a ^ 4'd2;
    n = 0;
    while (!(ack[k] || err[k]) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d latency a=%0d", k, a), 32'(n), 32'(lat));
    if (drop_stb) stb = 0;
    @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input int k, input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int lat);
    xfer(k, 1, a, d, s, lat, 0, 0, 0);
  endtask

  task automatic rd(input int k, input logic [3:0] a, input logic [31:0] ed,
                    input int lat);
    xfer(k, 0, a, 0, 0, lat, 0, 1, ed);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst state", 32'(st[0]), 0);
    check("rst ack", 32'(ack[0]), 0);
    check("rst dat", dout[0], 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("post-rst state", 32'(st[1]), 0);

    // WAIT_CYCLES=1: full and partial byte writes
    wr(0, 3, 32'hDEADBEEF, 4'hF, 1);
    rd(0, 3, 32'hDEADBEEF, 1);
    wr(0, 3, 32'h11223344, 4'b0101, 1);
    rd(0, 3, 32'hDE22BE44, 1);

    // Out-of-range index: one err pulse, data held, 00->11->00
    check("err pre state", 32'(st[0]), 0);
    xfer(0, 0, 9, 0, 0, 0, 1, 1, 32'hDE22BE44);
    check("err post state", 32'(st[0]), 0);
    check("err post err", 32'(err[0]), 0);
    check("err dat held", dout[0], 32'hDE22BE44);
    xfer(0, 0, 4'hF, 0, 0, 0, 1, 1, 32'hDE22BE44);

    // sel=0 write, dropped strobe in ACK, index latch
    wr(0, 3, 32'hFFFFFFFF, 4'h0, 1);
    rd(0, 3, 32'hDE22BE44, 1);
    xfer(0, 1, 4, 32'h12345678, 4'hF, 1, 0, 0, 0, 0, 1);
    rd(0, 4, 32'h0, 1);
    xfer(0, 1, 5, 32'hAABBCCDD, 4'hF, 1, 0, 0, 0, 1, 0);
    rd(0, 5, 32'hAABBCCDD, 1);
    rd(0, 7, 32'h0, 1);
    rd(0, 0, 32'h0, 1);

    // WAIT_CYCLES=3: abort on the second WAIT cycle
    wr(1, 2, 32'hCAFEF00D, 4'hF, 3);
    rd(1, 2, 32'hCAFEF00D, 3);
    dsel = 1; cyc = 1; stb = 1; we = 1; adr = 2;
    din = 32'h55555555; sel = 4'hF;
    @(posedge clk);
    #1;
    check("abort wait1", 32'(st[1]), 32'(WAIT));
    @(posedge clk);
    #1;
    check("abort wait2", 32'(st[1]), 32'(WAIT));
    cyc = 0; stb = 0; we = 0;
    @(posedge clk);
    #1;
    check("abort idle", 32'(st[1]), 32'(IDLE));
    repeat (4) @(posedge clk);
    #1;
    check("abort dat held", dout[1], 32'hCAFEF00D);
    rd(1, 2, 32'hCAFEF00D, 3);

    // WAIT_CYCLES=0: preload then held-strobe reads
    for (int i = 0; i < 4; i++)
      wr(2, 4'(i), 32'h11111111 * (i + 1), 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.is_err = 0;
      e.chk = 1;
      e.dat = 32'h11111111 * (i + 1);
      sbq[2].push_back(e);
    end
    dsel = 2; cyc = 1; stb = 1; we = 0; adr = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d ack state", i), 32'(st[2]), 32'(ACK));
      check($sformatf("b2b%0d ack", i), 32'(ack[2]), 1);
      if (i < 3) adr = 4'(i + 1);
      else begin
        cyc = 0; stb = 0;
      end
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d idle state", i), 32'(st[2]), 32'(IDLE));
      check($sformatf("b2b%0d no ack", i), 32'(ack[2]), 0);
    end

    // Asynchronous reset mid-WAIT during a write
    dsel = 1; cyc = 1; stb = 1; we = 1; adr = 7;
    din = 32'hFFFFFFFF; sel = 4'hF;
    @(posedge clk);
    #1;
    check("rst wait state", 32'(st[1]), 32'(WAIT));
    rst_n = 0;
    #1;
    check("async rst state", 32'(st[1]), 0);
    check("async rst ack", 32'(ack[1]), 0);
    check("async rst dat", dout[1], 0);
    cyc = 0; stb = 0; we = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    rd(1, 7, 32'h0, 3);
    rd(1, 2, 32'h0, 3);

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("dut%0d queue empty", k), 32'(sbq[k].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/wb_slave_fsm.md
# wb_slave_fsm

Wishbone classic (single-transfer) slave controller fronting a small 32-bit register bank, with a configurable number of wait states and an error response for out-of-range addresses. It is the design-under-check for the team's FSM assertion package. Its exported state vector and handshake outputs are the signals the valid-transition, output-valid and timeout properties bind to.

## Interface
- `ADDR_W`, 4: width of the word address; index = `wb_adr_i`.
- `NUM_REGS`, 8: implemented registers; legal range 1..2^ADDR_W.
- `WAIT_CYCLES`, 1: wait states inserted before ACK; legal range 0..15.
- `clk`  in  1  sample clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wb_cyc_i`  in  1  bus cycle in progress.
- `wb_stb_i`  in  1  strobe; a request is `wb_cyc_i & wb_stb_i`.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  ADDR_W  register index.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte enables; bit n covers bits [8n+7:8n].
- `wb_dat_o`  out  32  read data, registered.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.
- `state_o`  out  2  current FSM state, encoded as `state_t`; exported for assertion binding.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - ACK: normal termination.
  - ERR: error termination.
- IDLE transitions:
  - Request with `wb_adr_i >= NUM_REGS` → ERR.
  - Legal request with `WAIT_CYCLES == 0` → ACK.
  - Legal request with `WAIT_CYCLES > 0` → WAIT, with wait counter = `WAIT_CYCLES-1`.
  - No request → stay in IDLE.
- WAIT transitions:
  - `wb_cyc_i == 0` → IDLE (abort: no ack, no write, `wb_dat_o` unchanged).
  - Otherwise, counter == 0 → ACK.
  - Otherwise, decrement the counter and stay in WAIT.
- ACK → IDLE unconditionally. ERR → IDLE unconditionally.
- Moore outputs: `wb_ack_o = (state == ACK)`, `wb_err_o = (state == ERR)`. They are never both high and each is high for exactly one cycle per transfer.
- Read: on the edge entering ACK, `wb_dat_o` <= reg[index]. Otherwise `wb_dat_o` holds its value, including across ERR and aborts.
- Write: on the edge leaving ACK, if `wb_cyc_i & wb_stb_i & wb_we_i` is still high, bytes with `wb_sel_i` set take `wb_dat_i`; other bytes are unchanged. If the strobe dropped during the ACK cycle, the write is dropped but ACK still completes. `wb_sel_i == 0` writes nothing.
- Index latch: the address is captured at request acceptance in IDLE. Changes on `wb_adr_i` after acceptance are ignored.
- Back-to-back transfers: every transfer passes through IDLE, so a held strobe gives a new transfer every `WAIT_CYCLES+2` cycles.
- Reset: asynchronous. All outputs follow immediately:
  - state = IDLE;
  - `wb_ack_o` = 0, `wb_err_o` = 0;
  - `wb_dat_o` = 0;
  - all registers = 0;
  - wait counter = 0.

  Reset in the middle of a transfer discards it; there is no ack and no write.

## Timing
- Count the edge that samples the request in IDLE as edge 0.
- ACK is high in the cycle after edge `WAIT_CYCLES`. ERR is high in the cycle after edge 0.
- Read data is valid in the same cycle as `wb_ack_o`.
- Write data is sampled at the edge ending the ACK cycle.
- No combinational path from inputs to outputs.

## Structure
- Package `wb_slave_pkg`:
  - `typedef enum logic [1:0] state_t` with IDLE=2'b00, WAIT=2'b01, ACK=2'b10, ERR=2'b11;
  - `DATA_W` = 32;
  - `SEL_W` = 4.
- Sub-module `wb_regbank`: NUM_REGS×32 storage with byte-enabled write port and asynchronous read port, async active-low clear.
- `wb_slave_fsm` contains the FSM, the wait counter, the index latch and the read register.

## Test plan
- Reset, `WAIT_CYCLES=1`, write index 3 = 0xDEADBEEF with sel 4'hF, then read index 3 → ACK 2 cycles after each request is sampled; read returns 0xDEADBEEF.
- Write index 3 = 0x11223344 with sel 4'b0101, then read → 0xDE22BE44.
- Request at index 9 (NUM_REGS=8) → `wb_err_o` high exactly one cycle, no ack, `wb_dat_o` unchanged; state_o sequence 00→11→00.
- `WAIT_CYCLES=3`, drop `wb_cyc_i` on the second WAIT cycle → return to IDLE, no ack, no register change.
- Assert `rst_n` low in WAIT during a write → outputs cleared immediately, register stays 0; read after release → 0x00000000.
- `WAIT_CYCLES=0` with strobe held high, four consecutive reads → ack in every other cycle, state alternates 00/10, ack and err never both high.
